serial_comparator: RTL and testbench
====================================

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to compare a and b.
REQ-005 The block SHALL have port a, input, WIDTH, first unsigned operand, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH, second unsigned operand, sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1, high while a comparison is in progress (SHIFT or DONE).
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-009 The block SHALL have port diff, output, 1, high when a != b.
REQ-010 The block SHALL have port gt, output, 1, high when a > b.
REQ-011 The block SHALL have port lt, output, 1, high when a < b.

Function
REQ-012 The block SHALL implement a state machine with exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, start=1 at a clock edge SHALL capture a and b into internal shift registers, load the bit counter with WIDTH-1, clear the decision flags, and enter SHIFT.
REQ-014 start SHALL be ignored in SHIFT and DONE; operands SHALL NOT be re-sampled until the next IDLE acceptance.
REQ-015 Each SHIFT cycle SHALL compare the current MSBs of both shift registers, then shift both left by one bit.
REQ-016 On the first differing bit: diff SHALL be set, gt SHALL be set if a's bit=1, and lt SHALL be set if b's bit=1.
REQ-017 Once diff is set, later bits SHALL NOT modify diff, gt or lt.
REQ-018 SHIFT SHALL last exactly WIDTH cycles; there is no early exit. When the counter reaches 0, the next state SHALL be DONE.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 Latency SHALL be fixed: done is high in the (WIDTH+1)th cycle after the start acceptance edge.
REQ-021 diff, gt and lt SHALL be valid from the DONE cycle onward and held until the next start acceptance.
REQ-022 gt and lt SHALL never be high simultaneously; diff SHALL equal gt OR lt at done.
REQ-023 start held high continuously SHALL produce back-to-back comparisons, with one IDLE cycle between a DONE and the next acceptance.

Reset
REQ-024 reset=1 SHALL force the state to IDLE and set busy=0, done=0, diff=0, gt=0 and lt=0, and clear the shift registers and counter.
REQ-025 reset SHALL take priority over start and over any in-flight comparison; an aborted comparison SHALL produce no done pulse.
REQ-026 With reset=1 and start=1 on the same edge, the block SHALL NOT accept start.

Structure
REQ-027 A shared package SHALL hold the WIDTH default constant and the state enumeration (IDLE, SHIFT, DONE).
REQ-028 A sub-module, bit_cmp_cell, SHALL provide the per-bit combinational XOR difference and the a-bit-greater decision; the FSM, counter and shift registers remain in serial_comparator.

Verification
REQ-029 Reset then idle: reset=1 for 2 cycles -> busy=0, done=0, diff=0, gt=0, lt=0.
REQ-030 Equality: a=6'b000010, b=6'b000010, start pulse -> done in the 7th cycle after acceptance with diff=0, gt=0, lt=0.
REQ-031 Magnitude: a=6'b001010, b=6'b000101 -> diff=1, gt=1, lt=0; then a=6'b000001, b=6'b100000 -> diff=1, gt=0, lt=1.
REQ-032 First-differing-bit rule: a=6'b010000, b=6'b001111 -> gt=1, lt=0 despite b winning on the lower bits.
REQ-033 Busy ignore: second start with new operands 2 cycles after acceptance -> results reflect the first operands only, and exactly one done pulse.
REQ-034 Reset mid-operation: reset=1 in the 3rd SHIFT cycle -> IDLE next cycle, all outputs 0, no done pulse; a new start then completes normally.

Source files
------------

// File: rtl/serial_comparator_pkg.sv
// Shared constants and state encoding for the bit-serial magnitude comparator.
// Imported by serial_comparator and its bit_cmp_cell helper.
package serial_comparator_pkg;

  localparam int WIDTH_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_comparator_pkg

// File: rtl/serial_comparator_bit_cmp_cell.sv
// Single-bit comparison cell: flags a differing bit pair and whether a's bit wins.
// Purely combinational; the serial comparator feeds it the current operand MSBs.
module bit_cmp_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic differ,
  output logic a_greater
);

  assign differ    = a_bit ^ b_bit;
  assign a_greater = a_bit & ~b_bit;

endmodule : bit_cmp_cell

// File: rtl/serial_comparator.sv
// Bit-serial unsigned comparator: scans operands MSB-first, one bit per cycle,
// latching the verdict at the first differing bit. Fixed latency of WIDTH+1 cycles.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             diff,
  output logic             gt,
  output logic             lt
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, a_sr_next;
  logic [WIDTH-1:0] b_sr_reg, b_sr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             diff_reg, diff_next;
  logic             gt_reg, gt_next;
  logic             lt_reg, lt_next;

  logic             bit_differ;
  logic             bit_a_greater;

  bit_cmp_cell u_bit_cmp_cell (
    .a_bit     (a_sr_reg[WIDTH-1]),
    .b_bit     (b_sr_reg[WIDTH-1]),
    .differ    (bit_differ),
    .a_greater (bit_a_greater)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      cnt_reg   <= '0;
      diff_reg  <= 1'b0;
      gt_reg    <= 1'b0;
      lt_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_sr_reg  <= a_sr_next;
      b_sr_reg  <= b_sr_next;
      cnt_reg   <= cnt_next;
      diff_reg  <= diff_next;
      gt_reg    <= gt_next;
      lt_reg    <= lt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_sr_next  = a_sr_reg;
    b_sr_next  = b_sr_reg;
    cnt_next   = cnt_reg;
    diff_next  = diff_reg;
    gt_next    = gt_reg;
    lt_next    = lt_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          a_sr_next  = a;
          b_sr_next  = b;
          cnt_next   = CNT_W'(WIDTH - 1);
          diff_next  = 1'b0;
          gt_next    = 1'b0;
          lt_next    = 1'b0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_next = a_sr_reg << 1;
        b_sr_next = b_sr_reg << 1;
        // Only the first differing bit decides; later bits are don't-care.
        if (!diff_reg && bit_differ) begin
          diff_next = 1'b1;
          gt_next   = bit_a_greater;
          lt_next   = ~bit_a_greater;
        end
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign diff = diff_reg;
  assign gt   = gt_reg;
  assign lt   = lt_reg;

endmodule : serial_comparator

// File: tb/tb_serial_comparator.sv
// Directed self-checking bench for serial_comparator (WIDTH=6): latency, verdicts,
// start-while-busy, reset abort and back-to-back operation.
module tb_serial_comparator;

  localparam int W = 6;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         diff;
  logic         gt;
  logic         lt;

  int total;
  int bad;

  serial_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .gt    (gt),
    .lt    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one comparison from IDLE and returns in the done cycle (lat = cycles after acceptance).
  task automatic do_compare(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av;
    b = ~bv;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (diff !== 1'b0) begin bad++; $display("FAIL reset_diff got=%b want=0", diff); end
    total++; if (gt !== 1'b0) begin bad++; $display("FAIL reset_gt got=%b want=0", gt); end
    total++; if (lt !== 1'b0) begin bad++; $display("FAIL reset_lt got=%b want=0", lt); end
    // start together with reset must not be accepted
    start = 1'b1;
    a = 6'b111111;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_busy got=%b want=0", busy); end
    start = 1'b0;
    reset = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_after got=%b want=0", busy); end
    $display("test_reset: checked");
  endtask

  task automatic test_equal();
    int lat;
    do_compare(6'b000010, 6'b000010, lat);
    total++; if (lat !== W + 1) begin bad++; $display("FAIL eq_latency got=%0d want=%0d", lat, W + 1); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL eq_busy_in_done got=%b want=1", busy); end
    total++; if ({diff, gt, lt} !== 3'b000) begin bad++; $display("FAIL eq_flags got=%b want=000", {diff, gt, lt}); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL eq_after_done done=%b busy=%b want 0 0", done, busy); end
    $display("test_equal: a=000010 b=000010 lat=%0d flags=%b", lat, {diff, gt, lt});
  endtask

  task automatic test_magnitude();
    int lat;
    do_compare(6'b001010, 6'b000101, lat);
    total++; if (lat !== W + 1) begin bad++; $display("FAIL gt_latency got=%0d want=%0d", lat, W + 1); end
    total++; if ({diff, gt, lt} !== 3'b110) begin bad++; $display("FAIL gt_flags got=%b want=110", {diff, gt, lt}); end
    tick();
    tick();
    total++; if ({diff, gt, lt} !== 3'b110) begin bad++; $display("FAIL gt_flags_held got=%b want=110", {diff, gt, lt}); end
    $display("test_magnitude: a=001010 b=000101 flags=%b", {diff, gt, lt});
    do_compare(6'b000001, 6'b100000, lat);
    total++; if (lat !== W + 1) begin bad++; $display("FAIL lt_latency got=%0d want=%0d", lat, W + 1); end
    total++; if ({diff, gt, lt} !== 3'b101) begin bad++; $display("FAIL lt_flags got=%b want=101", {diff, gt, lt}); end
    tick();
    $display("test_magnitude: a=000001 b=100000 flags=%b", {diff, gt, lt});
  endtask

  task automatic test_first_bit();
    int lat;
    do_compare(6'b010000, 6'b001111, lat);
    total++; if ({diff, gt, lt} !== 3'b110) begin bad++; $display("FAIL first_bit_flags got=%b want=110", {diff, gt, lt}); end
    tick();
    do_compare(6'b111110, 6'b111111, lat);
    total++; if ({diff, gt, lt} !== 3'b101) begin bad++; $display("FAIL lsb_only_flags got=%b want=101", {diff, gt, lt}); end
    tick();
    $display("test_first_bit: 010000 vs 001111 and 111110 vs 111111 checked");
  endtask

  task automatic test_busy_ignore();
    int pulses;
    int first_done;
    a = 6'b000001;
    b = 6'b000010;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    a = 6'b111111;
    b = 6'b000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    first_done = 0;
    for (int c = 3; c <= 16; c++) begin
      if (done === 1'b1) begin
        pulses++;
        if (first_done == 0) first_done = c;
        total++; if ({diff, gt, lt} !== 3'b101) begin bad++; $display("FAIL busy_ignore_flags got=%b want=101", {diff, gt, lt}); end
      end
      tick();
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL busy_ignore_pulses got=%0d want=1", pulses); end
    total++; if (first_done !== W + 1) begin bad++; $display("FAIL busy_ignore_latency got=%0d want=%0d", first_done, W + 1); end
    $display("test_busy_ignore: pulses=%0d done_cycle=%0d", pulses, first_done);
  endtask

  task automatic test_reset_mid();
    int pulses;
    int lat;
    a = 6'b100000;
    b = 6'b000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if ({busy, done, diff, gt, lt} !== 5'b00000) begin bad++; $display("FAIL reset_mid_outputs got=%b want=00000", {busy, done, diff, gt, lt}); end
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL reset_mid_pulses got=%0d want=0", pulses); end
    do_compare(6'b000011, 6'b000111, lat);
    total++; if (lat !== W + 1) begin bad++; $display("FAIL reset_mid_restart_latency got=%0d want=%0d", lat, W + 1); end
    total++; if ({diff, gt, lt} !== 3'b101) begin bad++; $display("FAIL reset_mid_restart_flags got=%b want=101", {diff, gt, lt}); end
    tick();
    $display("test_reset_mid: aborted pulses=%0d restart lat=%0d", pulses, lat);
  endtask

  task automatic test_back_to_back();
    int c;
    int d1;
    int d2;
    a = 6'b000101;
    b = 6'b000011;
    start = 1'b1;
    tick();
    d1 = 0;
    d2 = 0;
    c = 1;
    while (d2 == 0 && c < 40) begin
      if (done === 1'b1) begin
        if (d1 == 0) d1 = c;
        else d2 = c;
      end
      if (d1 != 0 && c == d1 + 1) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap busy=%b want=0", busy); end
      end
      if (d2 == 0) begin
        tick();
        c++;
      end
    end
    total++; if (d1 !== W + 1) begin bad++; $display("FAIL b2b_first_done got=%0d want=%0d", d1, W + 1); end
    total++; if (d2 - d1 !== W + 2) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", d2 - d1, W + 2); end
    total++; if ({diff, gt, lt} !== 3'b110) begin bad++; $display("FAIL b2b_flags got=%b want=110", {diff, gt, lt}); end
    start = 1'b0;
    tick();
    tick();
    $display("test_back_to_back: done at %0d and %0d", d1, d2);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_equal();
    test_magnitude();
    test_first_bit();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_comparator
